// File: rtl/edge_generator.sv
// Pulse-train generator: emits num_pulses rectangular pulses of high_len/low_len
// cycles on x_out after a one-cycle start; all outputs come straight from flops.
module edge_generator #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StFinish} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [LEN_W-1:0] high_q, high_d;
  logic [LEN_W-1:0] low_q, low_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic             x_q, busy_q, done_q;

  // Next-state and phase/pulse counting; phase counter restarts at 1 on each
  // phase entry and is compared against the latched length, so it never wraps.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          num_d   = num_pulses;
          high_d  = (high_len == '0) ? LEN_W'(1) : high_len;
          low_d   = (low_len == '0) ? LEN_W'(1) : low_len;
          phase_d = LEN_W'(1);
          if (num_pulses == '0) begin
            cnt_d   = '0;
            state_d = StFinish;
          end else begin
            cnt_d   = NUM_W'(1);
            state_d = StHigh;
          end
        end
      end
      StHigh: begin
        if (abort) begin
          state_d = StIdle;
        end else if (phase_q == high_q) begin
          state_d = StLow;
          phase_d = LEN_W'(1);
        end else begin
          phase_d = phase_q + LEN_W'(1);
        end
      end
      StLow: begin
        if (abort) begin
          state_d = StIdle;
        end else if (phase_q == low_q) begin
          if (cnt_q < num_q) begin
            state_d = StHigh;
            phase_d = LEN_W'(1);
            cnt_d   = cnt_q + NUM_W'(1);
          end else begin
            state_d = StFinish;
          end
        end else begin
          phase_d = phase_q + LEN_W'(1);
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register; outputs are registered from the next state so x_out is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      x_q     <= (state_d == StHigh);
      busy_q  <= (state_d == StHigh) || (state_d == StLow);
      done_q  <= (state_d == StFinish);
    end
  end

  assign x_out     = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator: vector table plus hand-written corner sequences.
module tb_edge_generator;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] num_pulses, high_len, low_len;
  logic       x_out, busy, done;
  logic [7:0] pulse_cnt;

  int npass  = 0;
  int ntotal = 0;

  edge_generator #(.LEN_W(8), .NUM_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .num_pulses (num_pulses),
    .high_len   (high_len),
    .low_len    (low_len),
    .x_out      (x_out),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] n, h, l;
    logic       x, bsy, dn;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic s, logic [7:0] n, logic [7:0] h, logic [7:0] l,
                              logic x, logic b, logic d, logic [7:0] c);
    vec_t v;
    v.start = s; v.n = n; v.h = h; v.l = l;
    v.x = x; v.bsy = b; v.dn = d; v.cnt = c;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic go(input logic [7:0] n, input logic [7:0] h, input logic [7:0] l);
    start = 1'b1; num_pulses = n; high_len = h; low_len = l;
    step();
    start = 1'b0;
  endtask

  // Steps until done, returns cycles counted from the current cycle (0 on timeout).
  task automatic wait_done(input int cur, input int limit, output int at);
    at = 0;
    for (int i = cur; i <= limit; i++) begin
      if (done) begin
        at = i;
        break;
      end
      step();
    end
  endtask

  int edges;
  logic prev_x;
  int at;
  logic saw_done;

  initial begin
    // N=3 H=2 L=1: cycles 1..11 after start (inputs zeroed mid-train on purpose)
    tbl[0]  = mk(1, 3, 2, 1, 1, 1, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0, 2);
    tbl[4]  = mk(0, 0, 0, 0, 1, 1, 0, 2);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 2);
    tbl[6]  = mk(0, 0, 0, 0, 1, 1, 0, 3);
    tbl[7]  = mk(0, 0, 0, 0, 1, 1, 0, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 3);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    // N=0: done on cycle 1, nothing else moves
    tbl[11] = mk(1, 0, 5, 5, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    // N=2 H=0 L=0 treated as 1/1
    tbl[13] = mk(1, 2, 0, 0, 1, 1, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 1, 1, 0, 2);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 0, 2);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 2);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 2);

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    num_pulses = '0; high_len = '0; low_len = '0;
    step(); step();
    reset = 1'b0;
    check("reset x_out", x_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pulse_cnt", pulse_cnt, 0);

    edges = 0;
    prev_x = x_out;
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; num_pulses = tbl[i].n;
      high_len = tbl[i].h; low_len = tbl[i].l;
      step();
      start = 1'b0;
      check($sformatf("vec%0d x_out", i), x_out, tbl[i].x);
      check($sformatf("vec%0d busy", i), busy, tbl[i].bsy);
      check($sformatf("vec%0d done", i), done, tbl[i].dn);
      check($sformatf("vec%0d pulse_cnt", i), pulse_cnt, tbl[i].cnt);
      if (i <= 10) begin
        if (x_out && !prev_x) edges++;
        prev_x = x_out;
      end
      if (i == 10) check("rising edges N=3", edges, 3);
    end

    // Abort during second pulse (N=4 H=3 L=3), asserted on cycle 8
    go(4, 3, 3);
    for (int c = 2; c <= 8; c++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort x_out", x_out, 0);
    check("abort busy", busy, 0);
    check("abort pulse_cnt", pulse_cnt, 2);
    saw_done = done;
    for (int c = 0; c < 30; c++) begin
      step();
      saw_done = saw_done | done;
    end
    check("abort no done", saw_done, 0);
    check("abort stays idle", busy, 0);
    go(1, 1, 1);
    wait_done(1, 10, at);
    check("restart after abort done cycle", at, 3);
    check("restart after abort pulse_cnt", pulse_cnt, 1);

    // Start while busy must be ignored (N=2 H=4 L=4)
    step();
    go(2, 4, 4);
    step(); step();
    start = 1'b1; num_pulses = 9; high_len = 1; low_len = 1;
    step();
    start = 1'b0;
    wait_done(4, 40, at);
    check("ignored start done cycle", at, 17);
    check("ignored start pulse_cnt", pulse_cnt, 2);

    // start+abort in IDLE: abort wins
    step();
    start = 1'b1; abort = 1'b1; num_pulses = 3; high_len = 2; low_len = 2;
    step();
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", busy, 0);
    check("start+abort x_out", x_out, 0);
    step();
    check("start+abort still idle", busy, 0);

    // Reset on cycle 3 of an N=5 train
    go(5, 2, 2);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset x_out", x_out, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset pulse_cnt", pulse_cnt, 0);
    step();
    check("midreset stays idle", busy, 0);
    go(1, 1, 1);
    check("post-reset c1 x_out", x_out, 1);
    step();
    check("post-reset c2 x_out", x_out, 0);
    check("post-reset c2 busy", busy, 1);
    step();
    check("post-reset c3 done", done, 1);
    check("post-reset c3 busy", busy, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
